// File: rtl/mc_recon.sv
// Motion-compensation reconstruction: recon = clip(pred + residual), one row per transfer,
// with a single registered output stage, row tracking, end-of-block pulse and clip statistic.
module mc_recon #(
  parameter int unsigned MB_SIZE     = 4,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned RES_WIDTH   = 9,
  parameter int unsigned CNT_W       = $clog2(MB_SIZE * MB_SIZE + 1),
  localparam int unsigned RowW       = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PIXEL_WIDTH*MB_SIZE-1:0] pred_row,
  input  logic [RES_WIDTH*MB_SIZE-1:0]   residual,
  input  logic                           src_valid,
  output logic                           src_ready,
  output logic                           dst_valid,
  input  logic                           dst_ready,
  output logic [PIXEL_WIDTH*MB_SIZE-1:0] recon,
  output logic [RowW-1:0]                row_idx,
  output logic                           row_last,
  output logic                           mb_done,
  output logic [CNT_W-1:0]               clip_total
);

  localparam int unsigned SumW = PIXEL_WIDTH + 2;
  localparam logic signed [SumW-1:0] PixMax = SumW'((1 << PIXEL_WIDTH) - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e                         state_q, state_d;
  logic                           dst_valid_q;
  logic [PIXEL_WIDTH*MB_SIZE-1:0] recon_q;
  logic [RowW-1:0]                row_idx_q, in_row_q;
  logic                           row_last_q, mb_done_q;
  logic [CNT_W-1:0]               clip_acc_q, clip_total_q;

  logic                           in_fire, out_fire, last_in, blk_done;
  logic [PIXEL_WIDTH*MB_SIZE-1:0] row_recon;
  logic [CNT_W-1:0]               row_clips;
  logic [PIXEL_WIDTH-1:0]         pred_px, out_px;
  logic signed [RES_WIDTH-1:0]    res_px;
  logic signed [SumW-1:0]         sum;

  assign src_ready = !dst_valid_q || dst_ready;
  assign in_fire   = src_valid && src_ready;
  assign out_fire  = dst_valid_q && dst_ready;
  assign last_in   = (in_row_q == RowW'(MB_SIZE - 1));

  always_comb begin
    row_recon = '0;
    row_clips = '0;
    pred_px   = '0;
    res_px    = '0;
    sum       = '0;
    out_px    = '0;
    for (int i = 0; i < MB_SIZE; i++) begin
      pred_px = pred_row[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      res_px  = residual[i*RES_WIDTH +: RES_WIDTH];
      sum     = $signed({2'b00, pred_px}) + SumW'(res_px);
      if (sum < 0) begin
        out_px    = '0;
        row_clips = row_clips + CNT_W'(1);
      end else if (sum > PixMax) begin
        out_px    = '1;
        row_clips = row_clips + CNT_W'(1);
      end else begin
        out_px = sum[PIXEL_WIDTH-1:0];
      end
      row_recon[i*PIXEL_WIDTH +: PIXEL_WIDTH] = out_px;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_fire) state_d = last_in ? StDrain : StBusy;
      StBusy:  if (in_fire && last_in) state_d = StDrain;
      StDrain: begin
        // A new block's first row may be accepted in the same cycle the last row leaves.
        if (out_fire) begin
          if (in_fire) state_d = last_in ? StDrain : StBusy;
          else         state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    blk_done = (state_q == StDrain) && out_fire && row_last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_valid_q  <= 1'b0;
      recon_q      <= '0;
      row_idx_q    <= '0;
      row_last_q   <= 1'b0;
      in_row_q     <= '0;
      mb_done_q    <= 1'b0;
      clip_acc_q   <= '0;
      clip_total_q <= '0;
    end else begin
      mb_done_q <= blk_done;
      if (in_fire) begin
        dst_valid_q <= 1'b1;
        recon_q     <= row_recon;
        row_idx_q   <= in_row_q;
        row_last_q  <= last_in;
        in_row_q    <= last_in ? '0 : in_row_q + RowW'(1);
        if (last_in) begin
          clip_total_q <= clip_acc_q + row_clips;
          clip_acc_q   <= '0;
        end else begin
          clip_acc_q <= clip_acc_q + row_clips;
        end
      end else if (out_fire) begin
        dst_valid_q <= 1'b0;
      end
    end
  end

  assign dst_valid  = dst_valid_q;
  assign recon      = recon_q;
  assign row_idx    = row_idx_q;
  assign row_last   = row_last_q;
  assign mb_done    = mb_done_q;
  assign clip_total = clip_total_q;

endmodule

// File: tb/tb_mc_recon.sv
// Directed and random-stall bench for mc_recon at default parameters (4x4 block, 8-bit pixels).
module tb_mc_recon;

  logic        clk;
  logic        rst_n;
  logic [31:0] pred_row;
  logic [35:0] residual;
  logic        src_valid, src_ready, dst_valid, dst_ready;
  logic [31:0] recon;
  logic [1:0]  row_idx;
  logic        row_last, mb_done;
  logic [4:0]  clip_total;

  int n_checks = 0;
  int n_errors = 0;

  mc_recon dut (
    .clk        (clk),
    .reset      (rst_n),
    .pred_row   (pred_row),
    .residual   (residual),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .dst_valid  (dst_valid),
    .dst_ready  (dst_ready),
    .recon      (recon),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .mb_done    (mb_done),
    .clip_total (clip_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [35:0] rs4(input int a, input int b, input int c, input int d);
    return {d[8:0], c[8:0], b[8:0], a[8:0]};
  endfunction

  // Reference: clamp(pred + residual) into 0..255 per pixel.
  function automatic logic [31:0] model(input logic [31:0] p, input logic [35:0] r);
    logic [31:0]       o;
    logic signed [8:0] rv;
    int                s;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      rv = r[i*9 +: 9];
      s  = int'(p[i*8 +: 8]) + int'(rv);
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      o[i*8 +: 8] = s[7:0];
    end
    return o;
  endfunction

  task automatic push(input logic [31:0] p, input logic [35:0] r);
    pred_row  = p;
    residual  = r;
    src_valid = 1'b1;
    @(posedge clk);
    #1;
    src_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_row(input string tag, input logic [31:0] exp_recon, input int idx,
                         input bit last);
    check_eq({tag, " valid"}, 64'(dst_valid), 64'(1));
    check_eq({tag, " recon"}, 64'(recon), 64'(exp_recon));
    check_eq({tag, " row_idx"}, 64'(row_idx), 64'(idx));
    check_eq({tag, " row_last"}, 64'(row_last), 64'(last));
  endtask

  int          cyc, sent, taken, done_cnt, exp_idx, exp_in_row;
  bit          exp_valid, exp_last, exp_done, in_f, out_f;
  logic [31:0] exp_recon;
  logic [63:0] rnd;

  initial begin
    rst_n     = 1'b0;
    pred_row  = '0;
    residual  = '0;
    src_valid = 1'b0;
    dst_ready = 1'b1;
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst dst_valid", 64'(dst_valid), 64'(0));
    check_eq("rst recon", 64'(recon), 64'(0));
    check_eq("rst row_idx", 64'(row_idx), 64'(0));
    check_eq("rst row_last", 64'(row_last), 64'(0));
    check_eq("rst mb_done", 64'(mb_done), 64'(0));
    check_eq("rst clip_total", 64'(clip_total), 64'(0));
    check_eq("rst src_ready", 64'(src_ready), 64'(1));

    // Basic block: pred 0x10, residual +5,-3,0,+1 per row.
    push(px4(16, 16, 16, 16), rs4(5, 5, 5, 5));
    chk_row("basic r0", 32'h15151515, 0, 0);
    push(px4(16, 16, 16, 16), rs4(-3, -3, -3, -3));
    chk_row("basic r1", 32'h0D0D0D0D, 1, 0);
    push(px4(16, 16, 16, 16), rs4(0, 0, 0, 0));
    chk_row("basic r2", 32'h10101010, 2, 0);
    push(px4(16, 16, 16, 16), rs4(1, 1, 1, 1));
    chk_row("basic r3", 32'h11111111, 3, 1);
    check_eq("basic mb_done early", 64'(mb_done), 64'(0));
    check_eq("basic clip_total", 64'(clip_total), 64'(0));
    idle(1);
    check_eq("basic mb_done", 64'(mb_done), 64'(1));
    check_eq("basic drained", 64'(dst_valid), 64'(0));
    idle(1);
    check_eq("basic mb_done end", 64'(mb_done), 64'(0));

    // Saturation: 4 clips in row 0, 1 in row 1.
    push(px4(250, 3, 250, 3), rs4(10, -8, 10, -8));
    chk_row("sat r0", 32'h00FF00FF, 0, 0);
    push(px4(32, 32, 250, 32), rs4(0, 0, 10, 0));
    chk_row("sat r1", 32'h20FF2020, 1, 0);
    push(px4(32, 32, 32, 32), rs4(0, 0, 0, 0));
    push(px4(32, 32, 32, 32), rs4(0, 0, 0, 0));
    chk_row("sat r3", 32'h20202020, 3, 1);
    check_eq("sat clip_total", 64'(clip_total), 64'(5));
    idle(2);

    // Extreme residuals: 0xFF-256 clips to 0, 0x00+255 is exact.
    push(px4(255, 0, 128, 128), rs4(-256, 255, 0, 0));
    chk_row("ext r0", 32'h8080FF00, 0, 0);
    push(px4(1, 2, 3, 4), rs4(0, 0, 0, 0));
    push(px4(1, 2, 3, 4), rs4(0, 0, 0, 0));
    push(px4(1, 2, 3, 4), rs4(0, 0, 0, 0));
    check_eq("ext clip_total", 64'(clip_total), 64'(1));
    idle(2);

    // Back-to-back: two blocks, one row per cycle.
    for (int k = 0; k < 8; k++) begin
      if (k == 0)     push(px4(250, 3, 16, 16), rs4(10, -8, 0, 0));
      else if (k < 4) push(px4(64, 64, 64, 64), rs4(1, 1, 1, 1));
      else            push(px4(64, 64, 64, 64), rs4(-1, -1, -1, -1));
      chk_row($sformatf("b2b r%0d", k),
              (k == 0) ? 32'h101000FF : ((k < 4) ? 32'h41414141 : 32'h3F3F3F3F),
              k % 4, (k % 4) == 3);
      check_eq($sformatf("b2b mb_done %0d", k), 64'(mb_done), 64'(k == 4));
      if (k >= 3) check_eq($sformatf("b2b clip_total %0d", k), 64'(clip_total),
                           64'((k == 7) ? 0 : 2));
    end
    idle(1);
    check_eq("b2b mb_done 2nd", 64'(mb_done), 64'(1));
    idle(2);

    // Directed back-pressure: hold row 0 for 3 cycles with row 1 waiting.
    push(px4(32, 32, 32, 32), rs4(0, 0, 0, 0));
    dst_ready = 1'b0;
    pred_row  = px4(32, 32, 32, 32);
    residual  = rs4(1, 1, 1, 1);
    src_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      check_eq($sformatf("bp src_ready %0d", s), 64'(src_ready), 64'(0));
      @(posedge clk);
      #1;
      chk_row($sformatf("bp hold %0d", s), 32'h20202020, 0, 0);
    end
    dst_ready = 1'b1;
    #1;
    check_eq("bp release ready", 64'(src_ready), 64'(1));
    @(posedge clk);
    #1;
    src_valid = 1'b0;
    chk_row("bp r1", 32'h21212121, 1, 0);
    push(px4(32, 32, 32, 32), rs4(2, 2, 2, 2));
    chk_row("bp r2", 32'h22222222, 2, 0);
    push(px4(32, 32, 32, 32), rs4(3, 3, 3, 3));
    chk_row("bp r3", 32'h23232323, 3, 1);
    idle(2);

    // Random stalls on both sides: 16 blocks checked against a cycle model.
    cyc = 0; sent = 0; taken = 0; done_cnt = 0;
    exp_valid = 0; exp_done = 0; exp_last = 0; exp_idx = 0; exp_in_row = 0;
    exp_recon = '0;
    while ((taken < 64 || exp_done) && cyc < 3000) begin
      cyc++;
      dst_ready = ($urandom_range(0, 3) != 0);
      src_valid = (sent < 64) && ($urandom_range(0, 3) != 0);
      rnd       = {$urandom, $urandom};
      pred_row  = rnd[31:0];
      rnd       = {$urandom, $urandom};
      residual  = rnd[35:0];
      #1;
      check_eq("rnd dst_valid", 64'(dst_valid), 64'(exp_valid));
      check_eq("rnd mb_done", 64'(mb_done), 64'(exp_done));
      check_eq("rnd src_ready", 64'(src_ready), 64'(!exp_valid || dst_ready));
      if (mb_done) done_cnt++;
      in_f  = src_valid && (!exp_valid || dst_ready);
      out_f = exp_valid && dst_ready;
      if (out_f) begin
        check_eq("rnd row", {29'(0), row_last, row_idx, recon},
                 {29'(0), exp_last, 2'(exp_idx), exp_recon});
        taken++;
      end
      exp_done = out_f && exp_last;
      if (in_f) begin
        exp_recon  = model(pred_row, residual);
        exp_idx    = exp_in_row;
        exp_last   = (exp_in_row == 3);
        exp_in_row = (exp_in_row + 1) % 4;
        exp_valid  = 1;
        sent++;
      end else if (out_f) begin
        exp_valid = 0;
      end
      @(posedge clk);
      #1;
    end
    src_valid = 1'b0;
    dst_ready = 1'b1;
    check_eq("rnd timeout", 64'(cyc < 3000), 64'(1));
    check_eq("rnd rows taken", 64'(taken), 64'(64));
    check_eq("rnd blocks done", 64'(done_cnt), 64'(16));
    idle(2);

    // Reset mid-block after row 2 is accepted.
    push(px4(250, 250, 250, 250), rs4(10, 10, 10, 10));
    push(px4(250, 250, 250, 250), rs4(10, 10, 10, 10));
    push(px4(250, 250, 250, 250), rs4(10, 10, 10, 10));
    chk_row("mid r2", 32'hFFFFFFFF, 2, 0);
    rst_n = 1'b0;
    #1;
    check_eq("mid dst_valid", 64'(dst_valid), 64'(0));
    check_eq("mid recon", 64'(recon), 64'(0));
    check_eq("mid row_idx", 64'(row_idx), 64'(0));
    check_eq("mid clip_total", 64'(clip_total), 64'(0));
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid src_ready", 64'(src_ready), 64'(1));
    push(px4(64, 64, 64, 64), rs4(0, 0, 0, 0));
    chk_row("post r0", 32'h40404040, 0, 0);
    check_eq("post clip_total r0", 64'(clip_total), 64'(0));
    push(px4(64, 64, 64, 64), rs4(0, 0, 0, 0));
    push(px4(64, 64, 64, 64), rs4(0, 0, 0, 0));
    push(px4(64, 64, 64, 64), rs4(0, 0, 0, 0));
    chk_row("post r3", 32'h40404040, 3, 1);
    check_eq("post clip_total", 64'(clip_total), 64'(0));
    idle(1);
    check_eq("post mb_done", 64'(mb_done), 64'(1));
    idle(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
